mem_responder: RTL

- Memory-side responder for the tagged bus used by the icache, prefetch and dcache initiators.
- Each cycle it accepts at most one BUS_LOAD or BUS_STORE command.
- In the same cycle it answers with a nonzero transaction tag, or with 0 to reject.
- A load's 64-bit line returns exactly LATENCY cycles later, broadcast with its tag.
- It holds the backing storage array and is used as the synthesizable memory model in system benches.

---
 rtl/sys_defs.sv | 14 +
 rtl/mem_tag_alloc.sv | 23 ++
 rtl/mem_responder.sv | 115 +++++++++++
 3 files changed

// File: rtl/sys_defs.sv
// Bus command encoding and system-wide constants shared by the initiators and the memory model.
// The command encoding is fixed because the initiators drive it directly.
package sys_defs;

  localparam int XLEN        = 32;
  localparam int MEM_LATENCY = 20;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_command_t;

endpackage

// File: rtl/mem_tag_alloc.sv
// Lowest-free-tag picker over the busy vector. It is purely combinational.
// Tag i+1 corresponds to busy[i]. free_tag is 0 when any_free is low.
module mem_tag_alloc #(
  parameter int NUM_TAGS = 15
) (
  input  logic [NUM_TAGS-1:0] busy,
  output logic [3:0]          free_tag,
  output logic                any_free
);

  // Scan downwards so the last hit, which is the lowest free index, wins.
  always_comb begin
    free_tag = 4'd0;
    any_free = 1'b0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_tag = 4'(i + 1);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Tagged-bus memory responder. Accept or reject is combinational in the same cycle, and loads return after exactly LATENCY cycles.
// There is no queueing: a rejection happens when tags are exhausted or when it is injected, and the initiator retries.
module mem_responder
  import sys_defs::*;
#(
  parameter int NUM_TAGS  = 15,
  parameter int LATENCY   = MEM_LATENCY,
  parameter int MEM_WORDS = 8192
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      proc2mem_command,
  input  logic [XLEN-1:0] proc2mem_addr,
  input  logic [63:0]     proc2mem_data,
  input  logic            reject_inject,
  output logic [3:0]      mem2proc_response,
  output logic [3:0]      mem2proc_tag,
  output logic [63:0]     mem2proc_data
);

  localparam int IDXW = $clog2(MEM_WORDS);
  localparam int CW   = $clog2(LATENCY + 1);

  typedef struct packed {
    logic            valid;
    logic [3:0]      tag;
    logic [IDXW-1:0] index;
    logic [CW-1:0]   count;
  } load_slot_t;

  load_slot_t          slots [NUM_TAGS];
  logic [63:0]         mem   [MEM_WORDS];
  logic [NUM_TAGS-1:0] busy;
  logic [3:0]          free_tag;
  logic                any_free;
  logic [3:0]          alloc_slot;
  logic [IDXW-1:0]     req_idx;
  logic                cmd_vld;
  logic                accept;
  logic                load_acc;
  logic                store_acc;
  logic                done_vld;
  logic [3:0]          done_tag;
  logic [IDXW-1:0]     done_index;
  logic                unused_addr_bits;

  // Slot i holds tag i+1, so the valid bits are the busy vector.
  always_comb begin
    for (int i = 0; i < NUM_TAGS; i++) busy[i] = slots[i].valid;
  end

  mem_tag_alloc #(.NUM_TAGS(NUM_TAGS)) u_tag_alloc (
    .busy     (busy),
    .free_tag (free_tag),
    .any_free (any_free)
  );

  assign req_idx          = proc2mem_addr[3 +: IDXW];
  assign unused_addr_bits = ^{proc2mem_addr[2:0], proc2mem_addr[XLEN-1:3+IDXW]};
  assign alloc_slot       = free_tag - 4'd1;

  assign cmd_vld   = (proc2mem_command == BUS_LOAD) || (proc2mem_command == BUS_STORE);
  assign accept    = !reset && cmd_vld && !reject_inject && any_free;
  assign load_acc  = accept && (proc2mem_command == BUS_LOAD);
  assign store_acc = accept && (proc2mem_command == BUS_STORE);

  assign mem2proc_response = accept ? free_tag : 4'd0;

  // One acceptance per cycle with fixed latency, so at most one slot can expire per cycle.
  always_comb begin
    done_vld   = 1'b0;
    done_tag   = 4'd0;
    done_index = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (slots[i].valid && slots[i].count == '0) begin
        done_vld   = 1'b1;
        done_tag   = slots[i].tag;
        done_index = slots[i].index;
      end
    end
  end

  // Storage is not reset, so its contents survive a reset.
  always_ff @(posedge clock) begin
    if (store_acc) mem[req_idx] <= proc2mem_data;
  end

  // The count is the value seen in cycle T+1, so it reaches zero in cycle T+LATENCY-1.
  // The read uses pre-edge storage, so a store in the completion cycle is not seen.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem2proc_tag  <= 4'd0;
      mem2proc_data <= 64'd0;
      for (int i = 0; i < NUM_TAGS; i++) slots[i] <= '0;
    end else begin
      mem2proc_tag  <= 4'd0;
      mem2proc_data <= 64'd0;
      for (int i = 0; i < NUM_TAGS; i++) begin
        if (slots[i].valid) begin
          if (slots[i].count == '0) slots[i].valid <= 1'b0;
          else                      slots[i].count <= slots[i].count - 1'b1;
        end
      end
      if (done_vld) begin
        mem2proc_tag  <= done_tag;
        mem2proc_data <= mem[done_index];
      end
      if (load_acc) begin
        slots[alloc_slot] <= '{valid: 1'b1, tag: free_tag, index: req_idx,
                               count: CW'(LATENCY - 2)};
      end
    end
  end

endmodule
